// File: rtl/call_stack_n_pkg.sv
// ---------------------------------------------------------------------------
// call_stack_n_pkg
//    Shared definitions for the parametrised call/data stack.
//    - STACK_MODE_DROP / STACK_MODE_WRAP : values for the WRAP_MODE parameter,
//      also used by the control unit and the VGA CPU top when they configure
//      their stacks.
//    - stack_op_e : the four operations selected by {push,pop}.
//    - decode_op  : maps the raw push/pop strobes onto stack_op_e.
// ---------------------------------------------------------------------------
package call_stack_n_pkg;

   localparam int STACK_MODE_DROP = 0;
   localparam int STACK_MODE_WRAP = 1;

   // Encoding matches {push,pop}, so decoding is a plain cast.
   typedef enum logic [1:0] {
      OP_HOLD    = 2'b00,
      OP_POP     = 2'b01,
      OP_PUSH    = 2'b10,
      OP_REPLACE = 2'b11
   } stack_op_e;

   function automatic stack_op_e decode_op(input logic push, input logic pop);
      return stack_op_e'({push, pop});
   endfunction

endpackage

// File: rtl/call_stack_n_regfile.sv
// ---------------------------------------------------------------------------
// call_stack_n_regfile
//    Storage array behind call_stack_n. One synchronous write port and one
//    asynchronous read port. Contents are deliberately not reset: the stack
//    logic never shows an entry it has not written since reset.
// Ports
//    clk    in  1      system clock, rising edge
//    we     in  1      write enable
//    waddr  in  AW     write address, always < DEPTH
//    wdata  in  WIDTH  write data
//    raddr  in  AW     read address, always < DEPTH
//    rdata  out WIDTH  combinational read data
// ---------------------------------------------------------------------------
module call_stack_n_regfile
   import call_stack_n_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port: one entry per clock when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read port is asynchronous so the top of stack is visible in the same
   // cycle the pointer moves.
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack_n.sv
// ---------------------------------------------------------------------------
// call_stack_n
//    Parametrised LIFO for subroutine return addresses and data push/pop.
//    Holds the top/base pointers, occupancy count and sticky error flags,
//    decodes {push,pop} and drives the storage array.
// Parameters
//    WIDTH      bits per entry
//    DEPTH      number of entries (>= 2, any value)
//    WRAP_MODE  STACK_MODE_DROP: push on full is dropped
//               STACK_MODE_WRAP: push on full overwrites the oldest entry
//    CW         width of count (derived)
// Ports
//    clk      in  1      system clock, rising edge
//    reset    in  1      asynchronous reset, active low
//    push     in  1      push din as the new top
//    pop      in  1      remove the top entry
//    din      in  WIDTH  data to push
//    clr_err  in  1      clear sticky ovf/unf
//    dout     out WIDTH  current top of stack, 0 when empty
//    count    out CW     number of valid entries
//    empty    out 1      count == 0
//    full     out 1      count == DEPTH
//    ovf      out 1      sticky: push while full (without pop)
//    unf      out 1      sticky: pop while empty (without push)
// ---------------------------------------------------------------------------
module call_stack_n
   import call_stack_n_pkg::*;
#(
   parameter int WIDTH     = 10,
   parameter int DEPTH     = 16,
   parameter int WRAP_MODE = STACK_MODE_DROP,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_err,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Pointer arithmetic wraps explicitly at DEPTH-1 so non power-of-two
   // depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      return (p == '0) ? LAST_PTR : p - PW'(1);
   endfunction

   logic [PW-1:0]    top_q,   top_d;
   logic [PW-1:0]    base_q,  base_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q,   ovf_d;
   logic             unf_q,   unf_d;

   logic             is_empty;
   logic             is_full;
   logic [PW-1:0]    top_inc;
   stack_op_e        op;

   logic             mem_we;
   logic [PW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             ovf_set;
   logic             unf_set;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == FULL_CNT);
   assign top_inc  = ptr_inc(top_q);
   assign op       = decode_op(push, pop);

   // Operation decode: computes next pointers/count, the storage write and
   // which sticky error (if any) this cycle raises.
   always_comb begin
      top_d     = top_q;
      base_d    = base_q;
      count_d   = count_q;
      mem_we    = 1'b0;
      mem_waddr = top_inc;
      mem_wdata = din;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;

      unique case (op)
         OP_HOLD: begin
         end

         OP_PUSH: begin
            if (!is_full) begin
               mem_we  = 1'b1;
               top_d   = top_inc;
               count_d = count_q + CW'(1);
               // The first entry after empty is also the oldest one.
               if (is_empty) begin
                  base_d = top_inc;
               end
            end else begin
               ovf_set = 1'b1;
               // Circular mode: overwrite the oldest slot and slide the base.
               if (WRAP_MODE == STACK_MODE_WRAP) begin
                  mem_we = 1'b1;
                  top_d  = top_inc;
                  base_d = ptr_inc(base_q);
               end
            end
         end

         OP_POP: begin
            if (!is_empty) begin
               top_d   = ptr_dec(top_q);
               count_d = count_q - CW'(1);
            end else begin
               unf_set = 1'b1;
            end
         end

         OP_REPLACE: begin
            // On an empty stack push+pop degenerates to a plain push.
            if (is_empty) begin
               mem_we  = 1'b1;
               top_d   = top_inc;
               base_d  = top_inc;
               count_d = CW'(1);
            end else begin
               mem_we    = 1'b1;
               mem_waddr = top_q;
            end
         end

         default: begin
         end
      endcase
   end

   // Sticky flags: a new error in the same cycle as clr_err wins.
   always_comb begin
      ovf_d = ovf_set | (ovf_q & ~clr_err);
      unf_d = unf_set | (unf_q & ~clr_err);
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         top_q   <= '0;
         base_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         base_q  <= base_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   call_stack_n_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (top_q),
      .rdata (mem_rdata)
   );

   // Storage is not cleared on reset, so the read data is masked when empty.
   assign dout  = is_empty ? '0 : mem_rdata;
   assign count = count_q;
   assign empty = is_empty;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_call_stack_n.sv
// ---------------------------------------------------------------------------
// tb_call_stack_n
//    Drives a drop-mode and a wrap-mode stack (WIDTH=10, DEPTH=4) with the
//    same directed and random operations and compares both against a
//    queue-based model of a LIFO.
// ---------------------------------------------------------------------------
module tb_call_stack_n;

   localparam int W = 10;
   localparam int D = 4;
   localparam int C = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         push = 1'b0;
   logic         pop = 1'b0;
   logic         clr_err = 1'b0;
   logic [W-1:0] din = '0;

   logic [W-1:0] dout0, dout1;
   logic [C-1:0] count0, count1;
   logic         empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;

   int checks = 0;
   int failures = 0;

   // Reference model: back of queue is the top of stack.
   logic [W-1:0] q_drop [$];
   logic [W-1:0] q_wrap [$];
   logic         m_ovf [2];
   logic         m_unf [2];

   always #5 clk = ~clk;

   call_stack_n #(.WIDTH(W), .DEPTH(D), .WRAP_MODE(0)) dut_drop (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
      .clr_err(clr_err), .dout(dout0), .count(count0), .empty(empty0),
      .full(full0), .ovf(ovf0), .unf(unf0)
   );

   call_stack_n #(.WIDTH(W), .DEPTH(D), .WRAP_MODE(1)) dut_wrap (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
      .clr_err(clr_err), .dout(dout1), .count(count1), .empty(empty1),
      .full(full1), .ovf(ovf1), .unf(unf1)
   );

   task automatic modelReset();
      q_drop.delete();
      q_wrap.delete();
      for (int m = 0; m < 2; m++) begin
         m_ovf[m] = 1'b0;
         m_unf[m] = 1'b0;
      end
   endtask

   task automatic modelStep(input logic p, input logic o, input logic [W-1:0] d, input logic c);
      for (int m = 0; m < 2; m++) begin
         logic [W-1:0] s [$];
         logic ovf_e;
         logic unf_e;
         ovf_e = 1'b0;
         unf_e = 1'b0;
         if (m == 0) s = q_drop; else s = q_wrap;
         if (p && o) begin
            if (s.size() == 0) s.push_back(d);
            else s[s.size()-1] = d;
         end else if (p) begin
            if (s.size() < D) s.push_back(d);
            else begin
               ovf_e = 1'b1;
               if (m == 1) begin
                  void'(s.pop_front());
                  s.push_back(d);
               end
            end
         end else if (o) begin
            if (s.size() > 0) void'(s.pop_back());
            else unf_e = 1'b1;
         end
         m_ovf[m] = ovf_e | (m_ovf[m] & ~c);
         m_unf[m] = unf_e | (m_unf[m] & ~c);
         if (m == 0) q_drop = s; else q_wrap = s;
      end
   endtask

   task automatic checkVal(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s mode=%0d observed=%0h expected=%0h", tag, m, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      for (int m = 0; m < 2; m++) begin
         int           n;
         logic [W-1:0] top;
         if (m == 0) n = q_drop.size(); else n = q_wrap.size();
         top = '0;
         if (n > 0) top = (m == 0) ? q_drop[n-1] : q_wrap[n-1];
         if (m == 0) begin
            checkVal({tag, ".dout"},  m, 32'(dout0),  32'(top));
            checkVal({tag, ".count"}, m, 32'(count0), 32'(n));
            checkVal({tag, ".empty"}, m, 32'(empty0), 32'(n == 0));
            checkVal({tag, ".full"},  m, 32'(full0),  32'(n == D));
            checkVal({tag, ".ovf"},   m, 32'(ovf0),   32'(m_ovf[0]));
            checkVal({tag, ".unf"},   m, 32'(unf0),   32'(m_unf[0]));
         end else begin
            checkVal({tag, ".dout"},  m, 32'(dout1),  32'(top));
            checkVal({tag, ".count"}, m, 32'(count1), 32'(n));
            checkVal({tag, ".empty"}, m, 32'(empty1), 32'(n == 0));
            checkVal({tag, ".full"},  m, 32'(full1),  32'(n == D));
            checkVal({tag, ".ovf"},   m, 32'(ovf1),   32'(m_ovf[1]));
            checkVal({tag, ".unf"},   m, 32'(unf1),   32'(m_unf[1]));
         end
      end
   endtask

   // One clocked operation: drive on the falling edge, update the model at
   // the rising edge, check shortly after it.
   task automatic applyStimulus(input string tag, input logic p, input logic o,
                                input logic [W-1:0] d, input logic c);
      @(negedge clk);
      push = p;
      pop = o;
      din = d;
      clr_err = c;
      @(posedge clk);
      modelStep(p, o, d, c);
      #1;
      push = 1'b0;
      pop = 1'b0;
      clr_err = 1'b0;
      checkOutput(tag);
   endtask

   // Reset asserted between edges must take effect without a clock.
   task automatic midReset(input string tag);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      modelReset();
      checkOutput(tag);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      modelReset();
      #2;
      reset = 1'b0;
      #1;
      checkOutput("reset");
      @(negedge clk);
      reset = 1'b1;

      // Basic push/pop ordering
      applyStimulus("t1_push", 1, 0, 10'h005, 0);
      applyStimulus("t1_push", 1, 0, 10'h00A, 0);
      applyStimulus("t1_push", 1, 0, 10'h0F0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("t1_pop", 0, 1, '0, 0);

      // Underflow and its clearing
      applyStimulus("t2_unf", 0, 1, '0, 0);
      applyStimulus("t2_clr", 0, 0, '0, 1);
      applyStimulus("t2_clr_pop", 0, 1, '0, 1);
      applyStimulus("t2_clr2", 0, 0, '0, 1);

      // Fill past full: drop vs wrap
      for (int i = 1; i <= 6; i++) applyStimulus("t34_push", 1, 0, 10'(i), 0);
      for (int i = 0; i < 5; i++) applyStimulus("t34_pop", 0, 1, '0, 0);
      applyStimulus("t34_clr", 0, 0, '0, 1);

      // Replace-top cases
      applyStimulus("t5_push", 1, 0, 10'd7, 0);
      applyStimulus("t5_repl", 1, 1, 10'd9, 0);
      for (int i = 0; i < 3; i++) applyStimulus("t5_fill", 1, 0, 10'(20 + i), 0);
      applyStimulus("t5_repl_full", 1, 1, 10'h155, 0);
      for (int i = 0; i < 4; i++) applyStimulus("t5_pop", 0, 1, '0, 0);
      applyStimulus("t5_repl_empty", 1, 1, 10'd2, 0);

      // Reset mid-sequence
      for (int i = 0; i < 3; i++) applyStimulus("t6_push", 1, 0, 10'(i + 1), 0);
      midReset("t6_reset");
      applyStimulus("t6_push_after", 1, 0, 10'h3FF, 0);

      // Random operations
      for (int i = 0; i < 400; i++) begin
         int r;
         logic p, o, c;
         r = int'($urandom_range(0, 99));
         p = (r < 45) || (r >= 85);
         o = (r >= 45);
         c = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 79) == 0) midReset("rnd_reset");
         else applyStimulus("rnd", p, o, 10'($urandom_range(0, 1023)), c);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
